// File: rtl/seg_marquee.sv
// seg_marquee: scrolls a NUM_DIGITS-wide seven-segment window over a writable ring buffer.
// Optional blink gating (extra input port blink) is compiled in with `define SEG_MARQUEE_BLINK_EN.
module seg_marquee #(
   parameter int NUM_DIGITS = 8,
   parameter int SEG_W      = 7,
   parameter int MSG_DEPTH  = 16,
   parameter int CLK_HZ     = 50000000,
   parameter int STEP_HZ    = 1
) (
   input  logic                            clk50,
   input  logic                            rst_n,
   input  logic                            wr_en,
   input  logic [$clog2(MSG_DEPTH)-1:0]    wr_addr,
   input  logic [SEG_W-1:0]                wr_data,
   input  logic [$clog2(MSG_DEPTH+1)-1:0]  msg_len,
   input  logic                            start,
   input  logic                            stop,
   input  logic                            pause,
   input  logic                            dir,
   input  logic [1:0]                      speed,
   output logic [NUM_DIGITS*SEG_W-1:0]     seg_out,
   output logic                            step_tick,
   output logic                            busy
`ifdef SEG_MARQUEE_BLINK_EN
   ,
   input  logic                            blink
`endif
);

   localparam int AW  = $clog2(MSG_DEPTH);
   localparam int LW  = $clog2(MSG_DEPTH + 1);
   localparam int DIV = CLK_HZ / STEP_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [31:0] DIV_W = 32'(DIV);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                       state_r, state_n;
   logic [PW-1:0]                presc_r, presc_n;
   logic [AW-1:0]                ptr_r, ptr_n;
   logic [LW-1:0]                len_r, len_n;
   logic                         tick_r, tick_n;
   logic                         busy_r;
   logic [NUM_DIGITS*SEG_W-1:0]  seg_r, seg_n, win_s;
   logic [SEG_W-1:0]             mem_r [MSG_DEPTH];
   logic [31:0]                  div_sh_s, tc_s;
   logic                         wrap_s;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p,
                                               input logic [LW-1:0] len,
                                               input logic left);
      logic [AW-1:0] r;
      if (len == '0) begin
         r = '0;
      end else if (left) begin
         if (LW'(p) + LW'(1'b1) >= len) r = '0;
         else                           r = p + AW'(1'b1);
      end else begin
         if (p == '0) r = AW'(len - LW'(1'b1));
         else         r = p - AW'(1'b1);
      end
      return r;
   endfunction

   function automatic logic [AW-1:0] win_idx(input logic [AW-1:0] p, input int i,
                                              input logic [LW-1:0] len);
      logic [31:0] s;
      if (len == '0) s = 32'd0;
      else           s = (32'(p) + 32'(i)) % 32'(len);
      return AW'(s);
   endfunction

   // Terminal count follows speed combinationally so a rate change acts at once.
   always_comb begin
      div_sh_s = DIV_W >> speed;
      if (div_sh_s == 32'd0) tc_s = 32'd0;
      else                   tc_s = div_sh_s - 32'd1;
      wrap_s = (32'(presc_r) >= tc_s);
   end

   // Control state: stop beats start, start beats everything else.
   always_comb begin
      state_n = state_r;
      if (stop) begin
         state_n = IDLE;
      end else if (start) begin
         state_n = pause ? HOLD : RUN;
      end else begin
         case (state_r)
            IDLE:    state_n = IDLE;
            RUN:     state_n = pause ? HOLD : RUN;
            HOLD:    state_n = pause ? HOLD : RUN;
            default: state_n = IDLE;
         endcase
      end
   end

   // Prescaler, window pointer, latched length and step pulse.
   always_comb begin
      presc_n = presc_r;
      ptr_n   = ptr_r;
      len_n   = len_r;
      tick_n  = 1'b0;
      if (stop) begin
         presc_n = '0;
      end else if (start) begin
         presc_n = '0;
         ptr_n   = '0;
         len_n   = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
      end else if (state_r == RUN) begin
         if (wrap_s) begin
            presc_n = '0;
            ptr_n   = next_ptr(ptr_r, len_r, dir);
            tick_n  = 1'b1;
         end else begin
            presc_n = presc_r + PW'(1'b1);
         end
      end else if (state_r == HOLD) begin
`ifdef SEG_MARQUEE_BLINK_EN
         if (wrap_s) presc_n = '0;
         else        presc_n = presc_r + PW'(1'b1);
`else
         presc_n = presc_r;
`endif
      end else begin
         presc_n = '0;
      end
   end

   // Window extraction; the index wraps the ring so short messages repeat.
   always_comb begin
      win_s = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (len_r != '0) win_s[i*SEG_W +: SEG_W] = mem_r[win_idx(ptr_r, i, len_r)];
         else             win_s[i*SEG_W +: SEG_W] = '0;
      end
   end

`ifdef SEG_MARQUEE_BLINK_EN
   logic phase_r, phase_n;

   // Blink phase toggles on every terminal count while the marquee is active.
   always_comb begin
      phase_n = phase_r;
      if (stop || start || (state_r == IDLE)) phase_n = 1'b0;
      else if (wrap_s)                          phase_n = ~phase_r;
      else                                      phase_n = phase_r;
   end

   // Blink phase register.
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) phase_r <= 1'b0;
      else        phase_r <= phase_n;
   end
`endif

   // Display value for the next cycle.
   always_comb begin
      seg_n = '0;
      if (state_r == IDLE) begin
         seg_n = '0;
      end else begin
`ifdef SEG_MARQUEE_BLINK_EN
         if (blink && phase_r) seg_n = '0;
         else                  seg_n = win_s;
`else
         seg_n = win_s;
`endif
      end
   end

   // Message buffer, writable in any state.
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < MSG_DEPTH; k++) mem_r[k] <= '0;
      end else if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         presc_r <= '0;
         ptr_r   <= '0;
         len_r   <= '0;
         tick_r  <= 1'b0;
         busy_r  <= 1'b0;
         seg_r   <= '0;
      end else begin
         state_r <= state_n;
         presc_r <= presc_n;
         ptr_r   <= ptr_n;
         len_r   <= len_n;
         tick_r  <= tick_n;
         busy_r  <= (state_n != IDLE);
         seg_r   <= seg_n;
      end
   end

   assign seg_out   = seg_r;
   assign step_tick = tick_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_seg_marquee.sv
// Directed bench for seg_marquee with CLK_HZ=8, STEP_HZ=1 (eight cycles per step at speed 0).
module tb_seg_marquee;

   logic        clk50 = 1'b0;
   logic        rst_n, wr_en, start, stop, pause, dir;
   logic [3:0]  wr_addr;
   logic [6:0]  wr_data;
   logic [4:0]  msg_len;
   logic [1:0]  speed;
   logic [55:0] seg_out;
   logic        step_tick, busy;
`ifdef SEG_MARQUEE_BLINK_EN
   logic        blink = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic [4:0]  len;
      logic        d;
      logic [1:0]  spd;
      int          cyc;
      logic [55:0] exp;
   } vec_t;

   vec_t       vq[$];
   logic [6:0] img [16];

   seg_marquee #(
      .NUM_DIGITS(8), .SEG_W(7), .MSG_DEPTH(16), .CLK_HZ(8), .STEP_HZ(1)
   ) dut (
      .clk50(clk50), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .msg_len(msg_len), .start(start), .stop(stop), .pause(pause), .dir(dir),
      .speed(speed), .seg_out(seg_out), .step_tick(step_tick), .busy(busy)
`ifdef SEG_MARQUEE_BLINK_EN
      , .blink(blink)
`endif
   );

   always #5 clk50 = ~clk50;

   function automatic logic [55:0] pk(input logic [6:0] d0, d1, d2, d3, d4, d5, d6, d7);
      return {d7, d6, d5, d4, d3, d2, d1, d0};
   endfunction

   task automatic cyc();
      @(posedge clk50);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [6:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic do_start(input logic [4:0] l, input logic d, input logic [1:0] s);
      msg_len = l; dir = d; speed = s; start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_tick(input int lim, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (step_tick !== 1'b1 && n < lim);
   endtask

   task automatic addv(input string nm, input logic [4:0] l, input logic d,
                       input logic [1:0] s, input int c, input logic [55:0] e);
      vec_t v;
      v.name = nm; v.len = l; v.d = d; v.spd = s; v.cyc = c; v.exp = e;
      vq.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [55:0] p0, p1;
      int          n, tk;

      img[0] = 7'h76; img[1] = 7'h79; img[2] = 7'h38; img[3] = 7'h38;
      img[4] = 7'h3F; img[5] = 7'h00; img[6] = 7'h00; img[7] = 7'h00;
      for (int j = 8; j < 16; j++) img[j] = 7'(j - 7);
      p0 = pk(7'h76, 7'h79, 7'h38, 7'h38, 7'h3F, 7'h00, 7'h00, 7'h00);
      p1 = pk(7'h79, 7'h38, 7'h38, 7'h3F, 7'h00, 7'h00, 7'h00, 7'h76);

      addv("load_left",   5'd8,  1'b1, 2'd0, 1,  p0);
      addv("left_1step",  5'd8,  1'b1, 2'd0, 9,  p1);
      addv("right_1step", 5'd8,  1'b0, 2'd0, 9,
           pk(7'h00, 7'h76, 7'h79, 7'h38, 7'h38, 7'h3F, 7'h00, 7'h00));
      addv("right_wrap8", 5'd8,  1'b0, 2'd0, 65, p0);
      addv("len3_repeat", 5'd3,  1'b1, 2'd0, 1,
           pk(7'h76, 7'h79, 7'h38, 7'h76, 7'h79, 7'h38, 7'h76, 7'h79));
      addv("len3_left2",  5'd3,  1'b1, 2'd0, 17,
           pk(7'h38, 7'h76, 7'h79, 7'h38, 7'h76, 7'h79, 7'h38, 7'h76));
      addv("len20_clamp", 5'd20, 1'b0, 2'd0, 9,
           pk(7'h08, 7'h76, 7'h79, 7'h38, 7'h38, 7'h3F, 7'h00, 7'h00));
      addv("len16_left",  5'd16, 1'b1, 2'd0, 9,
           pk(7'h79, 7'h38, 7'h38, 7'h3F, 7'h00, 7'h00, 7'h00, 7'h01));
      addv("len0_blank",  5'd0,  1'b1, 2'd0, 9,  56'd0);
      addv("speed3_3st",  5'd8,  1'b1, 2'd3, 4,
           pk(7'h38, 7'h3F, 7'h00, 7'h00, 7'h00, 7'h76, 7'h79, 7'h38));
      addv("speed1_2st",  5'd8,  1'b1, 2'd1, 9,
           pk(7'h38, 7'h38, 7'h3F, 7'h00, 7'h00, 7'h00, 7'h76, 7'h79));

      rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 7'd0; msg_len = 5'd0;
      start = 1'b0; stop = 1'b0; pause = 1'b0; dir = 1'b1; speed = 2'd0;
      repeat (2) cyc();
      chk("rst_seg",  64'(seg_out),   64'd0);
      chk("rst_busy", 64'(busy),      64'd0);
      chk("rst_tick", 64'(step_tick), 64'd0);
      rst_n = 1'b1;
      cyc();

      for (int j = 0; j < 16; j++) wr(4'(j), img[j]);
      chk("idle_seg_blank", 64'(seg_out), 64'd0);

      // First step arrives on the eighth edge after start; window moves one edge later.
      do_start(5'd8, 1'b1, 2'd0);
      wait_tick(20, n);
      chk("first_tick_latency", 64'(n), 64'd8);
      cyc();
      chk("after_first_step", 64'(seg_out), 64'(p1));

      for (int i = 0; i < vq.size(); i++) begin
         do_start(vq[i].len, vq[i].d, vq[i].spd);
         repeat (vq[i].cyc) cyc();
         chk(vq[i].name, 64'(seg_out), 64'(vq[i].exp));
         chk({vq[i].name, "_busy"}, 64'(busy), 64'd1);
      end

      // An empty message still produces step pulses.
      do_start(5'd0, 1'b1, 2'd0);
      wait_tick(20, n);
      chk("len0_tick_latency", 64'(n), 64'd8);
      chk("len0_seg", 64'(seg_out), 64'd0);

      // Pause raised while the prescaler sits at 5, held for 20 cycles.
      do_start(5'd8, 1'b1, 2'd0);
      repeat (5) cyc();
      pause = 1'b1;
      tk = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (step_tick === 1'b1) tk++;
         chk("hold_seg_frozen", 64'(seg_out), 64'(p0));
      end
      chk("hold_no_tick", 64'(tk), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
      pause = 1'b0;
      cyc(); chk("resume_c1_tick", 64'(step_tick), 64'd0);
      cyc(); chk("resume_c2_tick", 64'(step_tick), 64'd0);
      cyc(); chk("resume_c3_tick", 64'(step_tick), 64'd1);
      cyc(); chk("resume_step_seg", 64'(seg_out), 64'(p1));

      // start and stop together: stop wins.
      start = 1'b1; stop = 1'b1;
      cyc();
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", 64'(busy), 64'd0);
      cyc();
      chk("startstop_seg", 64'(seg_out), 64'd0);
      tk = 0;
      repeat (12) begin
         cyc();
         if (step_tick === 1'b1) tk++;
      end
      chk("idle_no_tick", 64'(tk), 64'd0);

      // Fastest speed: terminal count 0, a step every cycle.
      do_start(5'd8, 1'b1, 2'd3);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("speed3_tick", 64'(step_tick), 64'd1);
      end

      // Speed 0 -> 2 with the prescaler at 4: immediate step, then every 2 cycles.
      do_start(5'd8, 1'b1, 2'd0);
      repeat (4) cyc();
      chk("pre_change_tick", 64'(step_tick), 64'd0);
      speed = 2'd2;
      cyc(); chk("spdchg_c1", 64'(step_tick), 64'd1);
      cyc(); chk("spdchg_c2", 64'(step_tick), 64'd0);
      cyc(); chk("spdchg_c3", 64'(step_tick), 64'd1);
      cyc(); chk("spdchg_c4", 64'(step_tick), 64'd0);
      cyc(); chk("spdchg_c5", 64'(step_tick), 64'd1);
      speed = 2'd0;

      // Start while paused lands in HOLD; a buffer write shows two edges later.
      pause = 1'b1;
      do_start(5'd8, 1'b1, 2'd0);
      cyc();
      chk("start_hold_seg", 64'(seg_out), 64'(p0));
      chk("start_hold_busy", 64'(busy), 64'd1);
      wr(4'd0, 7'h5B);
      chk("wr_edge1_seg", 64'(seg_out), 64'(p0));
      cyc();
      chk("wr_edge2_seg", 64'(seg_out),
          64'(pk(7'h5B, 7'h79, 7'h38, 7'h38, 7'h3F, 7'h00, 7'h00, 7'h00)));
      pause = 1'b0;

      // Asynchronous reset between clock edges while running.
      do_start(5'd8, 1'b1, 2'd0);
      repeat (3) cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_seg",  64'(seg_out), 64'd0);
      chk("async_rst_busy", 64'(busy),    64'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      do_start(5'd4, 1'b1, 2'd0);
      cyc();
      chk("post_rst_buf_clear", 64'(seg_out), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
